// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch front-end types and constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small fetch buffer of {pc, instr} entries with flush
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is accepted when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC gen, imem requests, fetch buffer, redirect
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instruction
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_fire, fifo_push, fifo_pop, fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head;

  assign occupancy      = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (out_q != '0);
  assign out_d          = out_q + CW'(req_fire) - CW'(rsp_fire);

  // Oldest in-flight request sits out_q words behind the next fetch address.
  assign push_entry.pc    = pc_q - (XLEN'(out_q) << 2);
  assign push_entry.instr = imem_rsp_data;
  assign fifo_push        = rsp_fire && !redirect_valid && (disc_q == '0);
  assign fifo_pop         = if_valid && id_ready;

  assign if_valid       = !fifo_empty;
  assign if_pc          = if_valid ? head.pc : '0;
  assign if_instruction = if_valid ? head.instr : NOP_INSTR;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      disc_d = out_d;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_fire && (disc_q != '0)) disc_d = disc_q - CW'(1);
    end
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      default: state_d = (disc_d == '0) ? S_RUN : S_DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .entry_i (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> (out_q != '0));
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full && !fifo_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int FIFO_DEPTH = 2;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, id_ready, if_valid;
  logic [31:0] redirect_pc, if_pc, if_instruction;

  logic        w_req_valid, w_ready, w_rsp_valid, w_redirect, w_id_ready, w_if_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_redirect_pc, w_if_pc, w_if_ins;

  logic        rsp_en;
  logic [31:0] pend[$], acc_addr[$], obs_pc[$], obs_ins[$];
  logic [31:0] exp_pc;
  int          total, bad;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(FIFO_DEPTH)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc), .id_ready(w_id_ready),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instruction(w_if_ins)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Memory model: in-order responses one cycle after accept, held while rsp_en=0.
  initial begin
    logic [31:0] a;
    imem_rsp_valid = 0;
    imem_rsp_data  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        imem_rsp_valid = 0;
      end else begin
        if (rsp_en && pend.size() > 0) begin
          a = pend.pop_front();
          imem_rsp_valid = 1;
          imem_rsp_data  = a ^ KEY;
        end else begin
          imem_rsp_valid = 0;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend.push_back(imem_req_addr);
          acc_addr.push_back(imem_req_addr);
        end
      end
    end
  end

  // Decode-side monitor: records every entry accepted by decode.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && if_valid && id_ready && !redirect_valid) begin
        obs_pc.push_back(if_pc);
        obs_ins.push_back(if_instruction);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr got=%h exp=0", imem_req_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
    total++; if (if_instruction !== 32'h13) begin bad++; $display("FAIL rst_if_instr got=%h exp=00000013", if_instruction); end
    total++; if (w_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_w_addr got=%h exp=fffffffc", w_req_addr); end
  endtask

  task automatic test_fetch_seq();
    logic [31:0] p, w;
    tick(); rst = 1;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_no_req got=%b exp=0", imem_req_valid); end
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    total++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", w_req_valid, w_req_addr); end
    @(negedge clk);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", if_valid); end
    total++; if (w_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_to_zero got=%h exp=0", w_req_addr); end
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== KEY) begin bad++; $display("FAIL lat_first got=%b/%h/%h exp=1/0/%h", if_valid, if_pc, if_instruction, KEY); end
    total++; if (w_req_valid !== 1'b0 || w_req_addr !== 32'h4) begin bad++; $display("FAIL wrap_limit got=%b/%h exp=0/4", w_req_valid, w_req_addr); end
    total++; if (w_if_valid !== 1'b0 || w_if_pc !== 32'h0 || w_if_ins !== 32'h13) begin bad++; $display("FAIL wrap_idle_out got=%b/%h/%h exp=0/0/13", w_if_valid, w_if_pc, w_if_ins); end
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_addr.size() <= i) begin bad++; $display("FAIL seq_addr%0d got=none exp=%h", i, 4*i); end
      else if (acc_addr[i] !== 32'(4*i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, acc_addr[i], 4*i); end
    end
    total++; if (obs_pc.size() < 4) begin bad++; $display("FAIL seq_count got=%0d exp>=4", obs_pc.size()); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL seq_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask

  task automatic test_stall();
    logic [31:0] p, w;
    int n0;
    tick(); id_ready = 0; n0 = acc_addr.size();
    repeat (5) @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_off got=%b exp=0", imem_req_valid); end
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stall_head got=%b exp=1", if_valid); end
    total++; if (acc_addr.size() - n0 > FIFO_DEPTH) begin bad++; $display("FAIL stall_accepts got=%0d exp<=%0d", acc_addr.size() - n0, FIFO_DEPTH); end
    tick(); id_ready = 1;
    repeat (12) @(negedge clk);
    total++; if (obs_pc.size() < 4) begin bad++; $display("FAIL stall_count got=%0d exp>=4", obs_pc.size()); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL stall_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] p, w;
    int n0;
    tick(); rsp_en = 0;
    repeat (6) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL pre_redir_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
    total++; if (pend.size() != 2) begin bad++; $display("FAIL inflight got=%0d exp=2", pend.size()); end
    tick(); redirect_valid = 1; redirect_pc = 32'h100;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_no_req got=%b exp=0", imem_req_valid); end
    tick(); redirect_valid = 0; rsp_en = 1;
    @(negedge clk);
    total++; if (dut.state_q !== S_DRAIN) begin bad++; $display("FAIL drain_state got=%0d exp=%0d", dut.state_q, S_DRAIN); end
    n0 = acc_addr.size();
    repeat (12) @(negedge clk);
    total++;
    if (acc_addr.size() <= n0) begin bad++; $display("FAIL redir_addr got=none exp=00000100"); end
    else if (acc_addr[n0] !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=00000100", acc_addr[n0]); end
    exp_pc = 32'h100;
    total++; if (obs_pc.size() < 3) begin bad++; $display("FAIL redir_count got=%0d exp>=3", obs_pc.size()); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL redir_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect_rsp();
    logic [31:0] p, w;
    int n0;
    tick(); imem_req_ready = 0;
    repeat (6) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL quiesce_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
    total++; if (pend.size() != 0) begin bad++; $display("FAIL quiesce_inflight got=%0d exp=0", pend.size()); end
    tick(); imem_req_ready = 1;
    tick(); imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h103;
    @(negedge clk);
    total++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL coincide_setup got=rsp%b/req%b exp=rsp1/req0", imem_rsp_valid, imem_req_valid); end
    n0 = acc_addr.size();
    tick(); redirect_valid = 0; imem_req_ready = 1;
    @(negedge clk);
    total++; if (dut.state_q !== S_RUN) begin bad++; $display("FAIL coincide_state got=%0d exp=%0d", dut.state_q, S_RUN); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL align_addr got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
    repeat (10) @(negedge clk);
    total++;
    if (acc_addr.size() <= n0) begin bad++; $display("FAIL align_accept got=none exp=00000100"); end
    else if (acc_addr[n0] !== 32'h100) begin bad++; $display("FAIL align_accept got=%h exp=00000100", acc_addr[n0]); end
    exp_pc = 32'h100;
    total++; if (obs_pc.size() < 3) begin bad++; $display("FAIL coincide_count got=%0d exp>=3", obs_pc.size()); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL coincide_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask

  task automatic test_ready_hold();
    logic [31:0] p, w;
    int n0;
    tick(); imem_req_ready = 0;
    repeat (6) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL hold_pre_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin bad++; $display("FAIL hold_cycle%0d got=%b/%h exp=1/%h", i, imem_req_valid, imem_req_addr, exp_pc); end
    end
    tick(); imem_req_ready = 1; n0 = acc_addr.size();
    repeat (10) @(negedge clk);
    total++;
    if (acc_addr.size() <= n0) begin bad++; $display("FAIL hold_accept got=none exp=%h", exp_pc); end
    else if (acc_addr[n0] !== exp_pc) begin bad++; $display("FAIL hold_accept got=%h exp=%h", acc_addr[n0], exp_pc); end
    total++; if (obs_pc.size() < 3) begin bad++; $display("FAIL hold_count got=%0d exp>=3", obs_pc.size()); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL hold_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p, w;
    int n0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_req got=%b/%h exp=0/0", imem_req_valid, imem_req_addr); end
    total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h13) begin bad++; $display("FAIL mid_rst_out got=%b/%h/%h exp=0/0/13", if_valid, if_pc, if_instruction); end
    total++; if (w_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL mid_rst_w_addr got=%h exp=fffffffc", w_req_addr); end
    obs_pc.delete(); obs_ins.delete();
    repeat (2) @(negedge clk);
    tick(); rst = 1; n0 = acc_addr.size();
    repeat (12) @(negedge clk);
    total++;
    if (acc_addr.size() <= n0) begin bad++; $display("FAIL restart_addr got=none exp=0"); end
    else if (acc_addr[n0] !== 32'h0) begin bad++; $display("FAIL restart_addr got=%h exp=0", acc_addr[n0]); end
    exp_pc = 32'h0;
    total++; if (obs_pc.size() < 4) begin bad++; $display("FAIL restart_count got=%0d exp>=4", obs_pc.size()); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); w = obs_ins.pop_front(); total++;
      if (p !== exp_pc || w !== (exp_pc ^ KEY)) begin bad++; $display("FAIL restart_entry got=%h/%h exp=%h/%h", p, w, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask

  initial begin
    total = 0; bad = 0; exp_pc = 0;
    rst = 0; imem_req_ready = 1; redirect_valid = 0; redirect_pc = 0; id_ready = 1; rsp_en = 1;
    w_ready = 1; w_rsp_valid = 0; w_rsp_data = 0; w_redirect = 0; w_redirect_pc = 0; w_id_ready = 0;
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect_drain();
    test_redirect_rsp();
    test_ready_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
